stack_arbiter: RTL and testbench

//  Shares one hardware stack (push/pop, registered peek, full/not_empty flags) between

---
 rtl/stack_arbiter_if.sv | 22 ++
 rtl/stack_arbiter.sv | 153 +++++++++++++++
 tb/tb_stack_arbiter.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/stack_arbiter_if.sv
// rtl/stack_arbiter_if.sv - requester-side handshake bundle for the shared stack arbiter
interface stack_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 2
);
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       op;
    logic [NREQ*WIDTH-1:0] wdata;
    logic [NREQ-1:0]       ack;
    logic                  err;
    logic [WIDTH-1:0]      rd_data;

    modport master (
        output req, op, wdata,
        input  ack, err, rd_data
    );

    modport slave (
        input  req, op, wdata,
        output ack, err, rd_data
    );
endinterface

// File: rtl/stack_arbiter.sv
// rtl/stack_arbiter.sv - round-robin arbiter sharing one hardware stack between requesters
module stack_arbiter #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3,
    parameter int NREQ  = 2
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             flush,
    stack_arbiter_if.slave   bus,
    output logic [DEPTH:0]   level,
    output logic             busy,
    output logic             stk_c,
    output logic             stk_en,
    output logic             stk_clr,
    output logic [WIDTH-1:0] stk_push,
    input  logic [WIDTH-1:0] stk_peek,
    input  logic             stk_full,
    input  logic             stk_ne
);

    typedef enum logic [2:0] {
        S_CLEAR, S_IDLE, S_ISSUE, S_DONE, S_ERROR, S_FLUSH
    } state_t;

    localparam int             IW      = (NREQ > 2) ? 2 : 1;
    localparam logic [DEPTH:0] LVL_ONE = 1;

    state_t            state_q, state_d;
    logic [IW-1:0]     rr_q, rr_d;
    logic [IW-1:0]     win_q, win_d, win_c;
    logic              any_req, reject;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic              err_q, err_d;
    logic [WIDTH-1:0]  rd_q, rd_d;
    logic [DEPTH:0]    level_d;
    logic              busy_d, stk_c_d, stk_en_d, stk_clr_d;
    logic [WIDTH-1:0]  stk_push_d;

    assign bus.ack     = ack_q;
    assign bus.err     = err_q;
    assign bus.rd_data = rd_q;

    // Search starts one past the last successful grant so every waiter is reached within NREQ turns.
    always_comb begin
        int idx;
        idx     = 0;
        win_c   = rr_q;
        any_req = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!any_req && bus.req[IW'(idx)]) begin
                win_c   = IW'(idx);
                any_req = 1'b1;
            end
        end
    end

    assign reject = bus.op[win_c] ? stk_full : !stk_ne;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q  <= S_CLEAR;
            rr_q     <= '0;
            win_q    <= '0;
            ack_q    <= '0;
            err_q    <= 1'b0;
            rd_q     <= '0;
            level    <= '0;
            busy     <= 1'b1;
            stk_c    <= 1'b0;
            stk_en   <= 1'b0;
            stk_clr  <= 1'b1;
            stk_push <= '0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            win_q    <= win_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            rd_q     <= rd_d;
            level    <= level_d;
            busy     <= busy_d;
            stk_c    <= stk_c_d;
            stk_en   <= stk_en_d;
            stk_clr  <= stk_clr_d;
            stk_push <= stk_push_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_CLEAR: state_d = S_IDLE;
            S_IDLE: begin
                if (flush)        state_d = S_FLUSH;
                else if (any_req) state_d = reject ? S_ERROR : S_ISSUE;
            end
            S_ISSUE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            S_ERROR: state_d = S_IDLE;
            S_FLUSH: state_d = S_IDLE;
            default: state_d = S_CLEAR;
        endcase
    end

    // Outputs are registered, so each value is computed for the state being entered.
    // Pop data is taken at the end of ISSUE, while the stack still shows the pre-pop top.
    always_comb begin
        ack_d      = '0;
        err_d      = 1'b0;
        stk_en_d   = 1'b0;
        stk_clr_d  = 1'b0;
        stk_c_d    = stk_c;
        stk_push_d = stk_push;
        rd_d       = rd_q;
        level_d    = level;
        rr_d       = rr_q;
        win_d      = win_q;
        busy_d     = (state_d != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (state_d == S_FLUSH) begin
                    stk_clr_d = 1'b1;
                    level_d   = '0;
                end else if (state_d != S_IDLE) begin
                    win_d      = win_c;
                    stk_c_d    = bus.op[win_c];
                    stk_push_d = bus.wdata[int'(win_c)*WIDTH +: WIDTH];
                    if (state_d == S_ISSUE) begin
                        stk_en_d = 1'b1;
                    end else begin
                        ack_d[win_c] = 1'b1;
                        err_d        = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                ack_d[win_q] = 1'b1;
                rr_d         = win_q;
                if (stk_c) begin
                    level_d = level + LVL_ONE;
                end else begin
                    level_d = level - LVL_ONE;
                    rd_d    = stk_peek;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_stack_arbiter.sv
// tb/tb_stack_arbiter.sv - directed self-checking bench for stack_arbiter with a behavioural stack
module tb_stack_arbiter;
    localparam int WIDTH = 8;
    localparam int DEPTH = 3;
    localparam int NREQ  = 2;

    logic             clk = 1'b0;
    logic             clr_n = 1'b0;
    logic             flush = 1'b0;
    logic [DEPTH:0]   level;
    logic             busy, stk_c, stk_en, stk_clr;
    logic [WIDTH-1:0] stk_push, stk_peek;
    logic             stk_full, stk_ne;

    int errors = 0;
    int checks = 0;

    stack_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

    stack_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NREQ(NREQ)) dut (
        .clk      (clk),
        .clr_n    (clr_n),
        .flush    (flush),
        .bus      (bus.slave),
        .level    (level),
        .busy     (busy),
        .stk_c    (stk_c),
        .stk_en   (stk_en),
        .stk_clr  (stk_clr),
        .stk_push (stk_push),
        .stk_peek (stk_peek),
        .stk_full (stk_full),
        .stk_ne   (stk_ne)
    );

    always #5 clk = ~clk;

    // Behavioural stack holding up to 2**DEPTH-1 entries
    logic [WIDTH-1:0] mem [8];
    int               cnt = 0;
    always @(posedge clk) begin
        if (stk_clr) begin
            cnt <= 0;
        end else if (stk_en) begin
            if (stk_c) begin
                mem[cnt] <= stk_push;
                cnt      <= cnt + 1;
            end else begin
                cnt <= cnt - 1;
            end
        end
    end
    assign stk_peek = (cnt == 0) ? '0 : mem[cnt-1];
    assign stk_full = (cnt == 7);
    assign stk_ne   = (cnt != 0);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_op(input int r, input logic o, input logic [7:0] d,
                         input logic e_err, input logic [7:0] e_rd, input int e_lvl);
        int   n;
        logic en_seen, got;
        @(negedge clk);
        bus.req[r]           = 1'b1;
        bus.op[r]            = o;
        bus.wdata[r*8 +: 8]  = d;
        n = 0; en_seen = 1'b0; got = 1'b0;
        while (!got && n < 8) begin
            @(negedge clk);
            n++;
            if (stk_en) en_seen = 1'b1;
            if (bus.ack[r]) got = 1'b1;
        end
        bus.req[r] = 1'b0;
        chk("ack_seen", 32'(got), 32'd1);
        chk("latency", n, e_err ? 32'd1 : 32'd2);
        chk("err", 32'(bus.err), 32'(e_err));
        chk("stk_en_pulse", 32'(en_seen), 32'(!e_err));
        chk("rd_data", 32'(bus.rd_data), 32'(e_rd));
        chk("level", 32'(level), e_lvl);
    endtask

    task automatic do_flush(input int lvl_before);
        chk("pre_flush_level", 32'(level), lvl_before);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_clr", 32'(stk_clr), 32'd1);
        chk("flush_level", 32'(level), 32'd0);
        chk("flush_busy", 32'(busy), 32'd1);
        chk("flush_noack", 32'(bus.ack), 32'd0);
        flush = 1'b0;
        @(negedge clk);
        chk("flush_clr_off", 32'(stk_clr), 32'd0);
        chk("flush_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        int   n, w, acks;
        logic got;
        bus.req = '0; bus.op = '0; bus.wdata = '0;

        // 1: reset state and first push
        repeat (2) @(negedge clk);
        chk("rst_clr", 32'(stk_clr), 32'd1);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_ack", 32'(bus.ack), 32'd0);
        chk("rst_en", 32'(stk_en), 32'd0);
        chk("rst_rd", 32'(bus.rd_data), 32'd0);
        clr_n = 1'b1;
        #1 chk("clear_hold", 32'(stk_clr), 32'd1);
        @(negedge clk);
        chk("clear_done", 32'(stk_clr), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        do_op(0, 1'b1, 8'hA5, 1'b0, 8'h00, 1);
        do_op(0, 1'b0, 8'h00, 1'b0, 8'hA5, 0);

        // 2: LIFO order
        do_op(0, 1'b1, 8'h11, 1'b0, 8'hA5, 1);
        do_op(1, 1'b1, 8'h22, 1'b0, 8'hA5, 2);
        do_op(0, 1'b0, 8'h00, 1'b0, 8'h22, 1);
        do_op(1, 1'b0, 8'h00, 1'b0, 8'h11, 0);

        // 3: underflow
        do_op(0, 1'b0, 8'h00, 1'b1, 8'h11, 0);

        // 4: fill then overflow
        for (int i = 0; i < 7; i++)
            do_op(0, 1'b1, 8'(8'h30 + i), 1'b0, 8'h11, i + 1);
        chk("full_flag", 32'(stk_full), 32'd1);
        do_op(0, 1'b1, 8'hEE, 1'b1, 8'h11, 7);
        do_flush(7);
        do_op(1, 1'b1, 8'h5A, 1'b0, 8'h11, 1);

        // 5: both requesters held, last grant was 1
        @(negedge clk);
        bus.op = 2'b11;
        bus.wdata = {8'h02, 8'h01};
        bus.req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            n = 0; got = 1'b0;
            while (!got && n < 8) begin
                @(negedge clk);
                n++;
                if (|bus.ack) got = 1'b1;
            end
            chk("rr_ack_seen", 32'(got), 32'd1);
            chk("rr_grant", 32'(bus.ack), (i % 2 == 0) ? 32'd1 : 32'd2);
            chk("rr_level", 32'(level), 32'(2 + i));
            w = bus.ack[1] ? 1 : 0;
            bus.req[w] = 1'b0;
            if (i < 2) begin
                @(negedge clk);
                bus.wdata[w*8 +: 8] = (w == 0) ? 8'h03 : 8'h04;
                bus.req[w] = 1'b1;
            end
        end
        do_op(0, 1'b0, 8'h00, 1'b0, 8'h04, 4);
        do_op(0, 1'b0, 8'h00, 1'b0, 8'h03, 3);

        // 6: flush at level 3, then async reset during ISSUE
        do_flush(3);
        do_op(0, 1'b0, 8'h00, 1'b1, 8'h03, 0);
        @(negedge clk);
        bus.req[0] = 1'b1; bus.op[0] = 1'b1; bus.wdata[7:0] = 8'h77;
        @(negedge clk);
        chk("issue_en", 32'(stk_en), 32'd1);
        #1 clr_n = 1'b0;
        #1;
        chk("arst_en", 32'(stk_en), 32'd0);
        chk("arst_clr", 32'(stk_clr), 32'd1);
        chk("arst_busy", 32'(busy), 32'd1);
        bus.req[0] = 1'b0;
        @(negedge clk);
        clr_n = 1'b1;
        acks = 0;
        repeat (4) begin
            @(negedge clk);
            if (|bus.ack) acks++;
        end
        chk("arst_noack", acks, 32'd0);
        chk("arst_level", 32'(level), 32'd0);
        chk("arst_idle", 32'(busy), 32'd0);
        do_op(0, 1'b0, 8'h00, 1'b1, 8'h00, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
